spi_adc_reader: RTL and testbench
=================================

Name: spi_adc_reader

Overview:
- Consumer end of the `trigger_control` pulse stream.
- On each one-cycle trigger pulse, it starts an ADC conversion by driving CNV high. It then clocks the result out of the ADC over a read-only SPI link (SCK generated, SDO sampled).
- It presents each sample on an AXI-Stream master with a one-deep output register.
- Lost triggers and lost samples are counted for software diagnostics.

Parameters:
- DATA_WIDTH, 16, bits per conversion, shifted MSB first; range 1..32.
- CONV_CYCLES, 40, clk cycles CNV is held high (ADC conversion time); must be >= 1.
- SCK_HALF, 2, clk cycles per SCK half-period; must be >= 1.

Ports:
- clk  in  1  system clock, 125 MHz.
- reset  in  1  asynchronous, active-high reset.
- trigger  in  1  conversion request, one-cycle pulse from trigger_control.
- spi_cnv  out  1  ADC convert-start.
- spi_sck  out  1  SPI clock, idle low.
- spi_sdo  in  1  ADC serial data, already synchronous to clk.
- m_axis_tdata  out  DATA_WIDTH  sample.
- m_axis_tvalid  out  1  sample valid.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  conversion or readout in progress.
- overrun_count  out  16  triggers ignored while busy, saturating.
- drop_count  out  16  samples discarded because the output register was full, saturating.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - All outputs 0: spi_cnv, spi_sck, m_axis_tvalid, m_axis_tdata, busy, both counters.
  - State returns to IDLE; shift register is cleared.
  - Reset mid-operation aborts the transfer; no partial sample is ever emitted.
- States: IDLE, CONVERT, SHIFT.
- IDLE:
  - trigger high at a clk edge moves to CONVERT.
  - spi_cnv=1 and busy=1 from that edge (edge 0).
- CONVERT:
  - Counter runs CONV_CYCLES cycles.
  - At edge CONV_CYCLES: spi_cnv=0, move to SHIFT, spi_sck=0, half-period counter cleared.
- SHIFT:
  - spi_sck toggles every SCK_HALF cycles.
  - spi_sdo is sampled into the shift register, MSB first, at the clk edge that drives spi_sck 1->0 (ADC data is stable through the high phase).
  - After the DATA_WIDTH-th falling SCK edge: spi_sck stays 0, busy=0, return to IDLE, and the result is offered to the output register on that same edge.
- Latency: trigger edge to the completion edge is CONV_CYCLES + 2*SCK_HALF*DATA_WIDTH clk cycles (defaults: 104).
- Output register:
  - tvalid is set on completion. It is held with tdata stable until a tvalid&&tready edge, then cleared.
  - Completion on the same edge the held sample is accepted: the new sample loads and tvalid stays 1.
  - Completion while tvalid=1 and tready=0: the new sample is discarded, the old one is kept, and drop_count increments.
- Triggers:
  - Every cycle with trigger=1 in CONVERT or SHIFT is ignored and increments overrun_count.
  - At the completion edge, state is still SHIFT, so a trigger there counts as an overrun.
  - The earliest accepted retrigger is the edge after completion.
- Counters:
  - 16-bit, saturate at 0xFFFF.
  - Cleared only by reset.
- m_axis_tdata is zero-extended nowhere; width is exactly DATA_WIDTH.

Test Plan:
- Defaults, one trigger pulse, ADC model returns 0xA5C3:
  - spi_cnv high exactly 40 cycles.
  - Exactly 16 SCK pulses, each 2 cycles low and 2 cycles high.
  - tvalid rises 104 cycles after the trigger edge with tdata=0xA5C3; busy low the same cycle.
- tready=0 for 500 cycles, two triggers 200 cycles apart, samples 0x1111 then 0x2222:
  - tdata stays 0x1111 and drop_count=1.
  - tready=1 accepts 0x1111, then tvalid=0.
- Trigger pulses at edges 0, 50 and 104 with tready=1:
  - overrun_count=2; only one sample emitted.
  - A trigger at edge 105 starts a new conversion.
- Assert reset at cycle 60 (mid-SHIFT) for 3 cycles:
  - spi_sck and spi_cnv go 0 immediately; no tvalid.
  - After release, the next trigger produces a full correct sample.
- Drive trigger continuously high for 70000 cycles:
  - overrun_count saturates at 0xFFFF.
  - Conversions repeat every 105 cycles with no X on outputs.
- Run with DATA_WIDTH=18, SCK_HALF=1, CONV_CYCLES=1, sample 0x2ABCD:
  - tvalid at 1+36=37 cycles with tdata=0x2ABCD.

Source files
------------

// File: rtl/spi_adc_reader.sv
// spi_adc_reader: trigger-driven ADC sampler. A trigger pulse starts a conversion
// (CNV high for CONV_CYCLES), then the result is clocked in over a read-only SPI
// link and offered to a one-deep AXI-Stream output register.
//
// Output handshake: a sample transfers on any clk edge where m_axis_tvalid and
// m_axis_tready are both 1; tvalid never drops and tdata never changes while a
// sample is waiting for tready.
module spi_adc_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int CONV_CYCLES = 40,
  parameter int SCK_HALF    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trigger,
  output logic                  spi_cnv,
  output logic                  spi_sck,
  input  logic                  spi_sdo,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic [15:0]           overrun_count,
  output logic [15:0]           drop_count,
  output logic [1:0]            dbg_state
);

  localparam int CCW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int HCW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CCW-1:0] CONV_LAST = CCW'(CONV_CYCLES - 1);
  localparam logic [HCW-1:0] HALF_LAST = HCW'(SCK_HALF - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_SHIFT   = 2'd2
  } state_t;

  state_t                r_state;
  logic [CCW-1:0]        r_conv_cnt;
  logic [HCW-1:0]        r_half_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic                  r_cnv;
  logic                  r_sck;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic [15:0]           r_overrun;
  logic [15:0]           r_drop;

  logic                  w_half_done;
  logic                  w_done;
  logic [DATA_WIDTH:0]   w_shift_ext;
  logic [DATA_WIDTH-1:0] w_shift_next;

  // The edge that ends an SCK half-period while SCK is high is the falling edge;
  // SDO is captured there. The last such edge completes the sample.
  assign w_half_done  = (r_half_cnt == HALF_LAST);
  assign w_done       = (r_state == S_SHIFT) && w_half_done && r_sck && (r_bit_cnt == BIT_LAST);
  assign w_shift_ext  = {r_shreg, spi_sdo};
  assign w_shift_next = w_shift_ext[DATA_WIDTH-1:0];

  // Conversion / readout sequencer with registered CNV, SCK and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_conv_cnt <= '0;
      r_half_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
      r_cnv      <= 1'b0;
      r_sck      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trigger) begin
            r_state    <= S_CONVERT;
            r_cnv      <= 1'b1;
            r_busy     <= 1'b1;
            r_conv_cnt <= '0;
          end
        end
        S_CONVERT: begin
          if (r_conv_cnt == CONV_LAST) begin
            r_state    <= S_SHIFT;
            r_cnv      <= 1'b0;
            r_sck      <= 1'b0;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
          end else begin
            r_conv_cnt <= r_conv_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_half_done) begin
            r_half_cnt <= '0;
            r_sck      <= ~r_sck;
            if (r_sck) begin
              r_shreg <= w_shift_next;
              if (r_bit_cnt == BIT_LAST) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end else begin
            r_half_cnt <= r_half_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnv   <= 1'b0;
          r_sck   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-deep output register: a completed sample loads if the slot is empty or
  // being drained this edge, otherwise it is dropped and counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
      r_drop   <= '0;
    end else if (w_done) begin
      if (!r_tvalid || m_axis_tready) begin
        r_tdata  <= w_shift_next;
        r_tvalid <= 1'b1;
      end else if (r_drop != 16'hFFFF) begin
        r_drop <= r_drop + 16'd1;
      end
    end else if (r_tvalid && m_axis_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  // Saturating count of triggers that arrive while a conversion is in flight,
  // including the completion edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= '0;
    end else if (trigger && (r_state != S_IDLE) && (r_overrun != 16'hFFFF)) begin
      r_overrun <= r_overrun + 16'd1;
    end
  end

  assign spi_cnv       = r_cnv;
  assign spi_sck       = r_sck;
  assign busy          = r_busy;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign overrun_count = r_overrun;
  assign drop_count    = r_drop;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_spi_adc_reader.sv
// Testbench for spi_adc_reader: directed scenarios plus a randomized run checked
// against a cycle-timeline reference model of the sampler and its output slot.
module tb_spi_adc_reader;

  localparam int W    = 16;
  localparam int CONV = 40;
  localparam int HALF = 2;
  localparam int LAT  = CONV + 2 * HALF * W;
  localparam int W2   = 18;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #4 clk = ~clk;

  // ---------------- DUT (default parameters) ----------------
  logic         trigger = 1'b0;
  logic         spi_sdo = 1'b0;
  logic         tready = 1'b0;
  logic         spi_cnv, spi_sck, tvalid, busy;
  logic [W-1:0] tdata;
  logic [15:0]  ovr, drp;
  logic [1:0]   dbg;

  spi_adc_reader #(.DATA_WIDTH(W), .CONV_CYCLES(CONV), .SCK_HALF(HALF)) u_dut (
    .clk(clk), .reset(reset), .trigger(trigger),
    .spi_cnv(spi_cnv), .spi_sck(spi_sck), .spi_sdo(spi_sdo),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .busy(busy), .overrun_count(ovr), .drop_count(drp), .dbg_state(dbg)
  );

  // ---------------- DUT (18-bit, fast) ----------------
  logic          trigger2 = 1'b0;
  logic          spi_sdo2 = 1'b0;
  logic          tready2 = 1'b1;
  logic          spi_cnv2, spi_sck2, tvalid2, busy2;
  logic [W2-1:0] tdata2;
  logic [15:0]   ovr2, drp2;
  logic [1:0]    dbg2;

  spi_adc_reader #(.DATA_WIDTH(W2), .CONV_CYCLES(1), .SCK_HALF(1)) u_dut2 (
    .clk(clk), .reset(reset), .trigger(trigger2),
    .spi_cnv(spi_cnv2), .spi_sck(spi_sck2), .spi_sdo(spi_sdo2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(tready2),
    .busy(busy2), .overrun_count(ovr2), .drop_count(drp2), .dbg_state(dbg2)
  );

  // ---------------- ADC models ----------------
  // The ADC captures its value when CNV rises, presents the MSB once CNV falls
  // and moves to the next bit on every falling SCK.
  logic [W-1:0]  adc_sample = '0;
  logic [W-1:0]  adc_shadow = '0;
  int            adc_idx = 0;
  logic [W2-1:0] adc2_sample = '0;
  logic [W2-1:0] adc2_shadow = '0;
  int            adc2_idx = 0;

  always @(posedge spi_cnv) adc_shadow = adc_sample;
  always @(negedge spi_cnv) begin
    adc_idx = W - 1;
    spi_sdo = adc_shadow[W-1];
  end
  always @(negedge spi_sck) begin
    if (adc_idx > 0) adc_idx = adc_idx - 1;
    spi_sdo = adc_shadow[adc_idx];
  end

  always @(posedge spi_cnv2) adc2_shadow = adc2_sample;
  always @(negedge spi_cnv2) begin
    adc2_idx = W2 - 1;
    spi_sdo2 = adc2_shadow[W2-1];
  end
  always @(negedge spi_sck2) begin
    if (adc2_idx > 0) adc2_idx = adc2_idx - 1;
    spi_sdo2 = adc2_shadow[adc2_idx];
  end

  // ---------------- reference model ----------------
  // Timeline view: an accepted trigger at edge n makes the sampler busy until
  // edge n+LAT, where the captured ADC value is offered to the output slot.
  int           errors = 0;
  int           checks = 0;
  int           n = 0;
  bit           m_active = 0;
  int           m_start = 0;
  int           m_end = 0;
  logic [W-1:0] m_cur = '0;
  logic [W-1:0] m_data = '0;
  bit           m_vld = 0;
  bit           m_cnv = 0;
  int           m_ovr = 0;
  int           m_drp = 0;

  task automatic model_reset();
    n = 0; m_active = 0; m_start = 0; m_end = 0; m_cur = '0;
    m_data = '0; m_vld = 0; m_cnv = 0; m_ovr = 0; m_drp = 0;
  endtask

  // Advance one clock: apply the model for the inputs present at this edge,
  // then return at the following negedge where outputs are sampled.
  task automatic tick();
    bit comp, acc;
    @(posedge clk);
    comp = m_active && (n == m_end);
    acc  = m_vld && tready;
    if (trigger) begin
      if (m_active) begin
        if (m_ovr < 65535) m_ovr++;
      end else begin
        m_active = 1; m_start = n; m_end = n + LAT; m_cur = adc_sample;
      end
    end
    if (comp) begin
      m_active = 0;
      if (!m_vld || tready) begin
        m_vld = 1; m_data = m_cur;
      end else if (m_drp < 65535) begin
        m_drp++;
      end
    end else if (acc) begin
      m_vld = 0;
    end
    m_cnv = m_active && ((n - m_start) < CONV);
    n++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    trigger = 0; trigger2 = 0;
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1;
    #1;
    checks++; if (spi_cnv !== 1'b0) begin errors++; $display("FAIL reset_cnv: got %b want 0", spi_cnv); end
    checks++; if (spi_sck !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", spi_sck); end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    checks++; if (tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %h want 0", tdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ovr !== 16'h0) begin errors++; $display("FAIL reset_overrun: got %h want 0", ovr); end
    checks++; if (drp !== 16'h0) begin errors++; $display("FAIL reset_drop: got %h want 0", drp); end
    checks++; if (dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg); end
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  task automatic test_single();
    int cnv_cnt = 0, sck_high = 0, rises = 0, first_rise = -1, tv_at = -1;
    logic prev_sck = 0;
    logic [W-1:0] tv_data = '0;
    logic tv_busy = 1;
    apply_reset();
    tready = 1; adc_sample = 16'hA5C3;
    trigger = 1;
    tick();
    trigger = 0;
    for (int rel = 0; rel < 200; rel++) begin
      if (spi_cnv) cnv_cnt++;
      if (spi_sck) begin
        sck_high++;
        if (!prev_sck) begin
          rises++;
          if (first_rise < 0) first_rise = rel;
        end
      end
      prev_sck = spi_sck;
      if (tvalid && tv_at < 0) begin
        tv_at = rel; tv_data = tdata; tv_busy = busy;
      end
      tick();
    end
    checks++; if (cnv_cnt != CONV) begin errors++; $display("FAIL single_cnv_width: got %0d want %0d", cnv_cnt, CONV); end
    checks++; if (rises != W) begin errors++; $display("FAIL single_sck_pulses: got %0d want %0d", rises, W); end
    checks++; if (sck_high != W * HALF) begin errors++; $display("FAIL single_sck_high: got %0d want %0d", sck_high, W * HALF); end
    checks++; if (first_rise != CONV + HALF) begin errors++; $display("FAIL single_first_rise: got %0d want %0d", first_rise, CONV + HALF); end
    checks++; if (tv_at != LAT) begin errors++; $display("FAIL single_latency: got %0d want %0d", tv_at, LAT); end
    checks++; if (tv_data !== 16'hA5C3) begin errors++; $display("FAIL single_tdata: got %h want a5c3", tv_data); end
    checks++; if (tv_busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_valid: got %b want 0", tv_busy); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    tready = 0;
    for (int i = 0; i < 500; i++) begin
      trigger = (i == 0 || i == 200);
      adc_sample = (i < 200) ? 16'h1111 : 16'h2222;
      tick();
    end
    trigger = 0;
    checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bp_tvalid_held: got %b want 1", tvalid); end
    checks++; if (tdata !== 16'h1111) begin errors++; $display("FAIL bp_tdata_kept: got %h want 1111", tdata); end
    checks++; if (drp !== 16'd1) begin errors++; $display("FAIL bp_drop_count: got %0d want 1", drp); end
    tready = 1;
    tick();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL bp_accept_clears: got %b want 0", tvalid); end
  endtask

  task automatic test_overrun();
    int early = 0;
    logic [W-1:0] s105 = '0;
    apply_reset();
    tready = 1;
    for (int i = 0; i <= 230; i++) begin
      trigger = (i == 0 || i == 50 || i == 104 || i == 105);
      adc_sample = W'($urandom);
      if (i == 105) s105 = adc_sample;
      tick();
      if (tvalid && i < 209) early++;
      if (i == 105) begin
        checks++; if (busy !== 1'b1 || spi_cnv !== 1'b1) begin errors++; $display("FAIL ovr_retrigger_105: busy=%b cnv=%b want 1 1", busy, spi_cnv); end
      end
      if (i == 209) begin
        checks++; if (tvalid !== 1'b1 || tdata !== s105) begin errors++; $display("FAIL ovr_second_sample: tvalid=%b tdata=%h want 1 %h", tvalid, tdata, s105); end
      end
    end
    trigger = 0;
    checks++; if (ovr !== 16'd2) begin errors++; $display("FAIL ovr_count: got %0d want 2", ovr); end
    checks++; if (early != 1) begin errors++; $display("FAIL ovr_one_sample: got %0d samples want 1", early); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, tv_at = -1;
    logic [W-1:0] tv_data = '0;
    apply_reset();
    tready = 1; adc_sample = 16'hBEEF;
    trigger = 1;
    tick();
    trigger = 0;
    repeat (60) tick();
    reset = 1;
    #1;
    checks++; if (spi_sck !== 1'b0 || spi_cnv !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: sck=%b cnv=%b busy=%b want 0 0 0", spi_sck, spi_cnv, busy); end
    repeat (3) @(negedge clk);
    reset = 0;
    model_reset();
    for (int i = 0; i < 150; i++) begin
      if (tvalid) seen++;
      tick();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_partial: got %0d valid cycles want 0", seen); end
    adc_sample = 16'h5A3C;
    trigger = 1;
    tick();
    trigger = 0;
    for (int rel = 0; rel < 150; rel++) begin
      if (tvalid && tv_at < 0) begin tv_at = rel; tv_data = tdata; end
      tick();
    end
    checks++; if (tv_at != LAT || tv_data !== 16'h5A3C) begin errors++; $display("FAIL rstmid_recover: at=%0d data=%h want %0d 5a3c", tv_at, tv_data, LAT); end
  endtask

  task automatic test_random();
    bit slow = 0;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) slow = ($urandom_range(0, 1) == 1);
      trigger = ($urandom_range(0, 59) == 0) || ($urandom_range(0, 999) < 3);
      tready = slow ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) != 0);
      adc_sample = W'($urandom);
      tick();
      checks++;
      if (tvalid !== m_vld || (m_vld && tdata !== m_data) || busy !== m_active ||
          spi_cnv !== m_cnv || ovr !== 16'(m_ovr) || drp !== 16'(m_drp)) begin
        errors++;
        $display("FAIL random_cycle %0d: got v=%b d=%h b=%b c=%b o=%0d dr=%0d want v=%b d=%h b=%b c=%b o=%0d dr=%0d",
                 i, tvalid, tdata, busy, spi_cnv, ovr, drp, m_vld, m_data, m_active, m_cnv, m_ovr, m_drp);
      end
    end
    trigger = 0;
  endtask

  task automatic test_saturation();
    int xs = 0, bad_gap = 0, last = -1, pulses = 0;
    apply_reset();
    tready = 1;
    trigger = 1;
    for (int i = 0; i < 70000; i++) begin
      adc_sample = W'($urandom);
      tick();
      if ($isunknown({spi_cnv, spi_sck, tvalid, tdata, busy, ovr, drp})) xs++;
      if (tvalid) begin
        pulses++;
        if (last >= 0 && (i - last) != LAT + 1) bad_gap++;
        last = i;
      end
      checks++;
      if (tvalid !== m_vld || (m_vld && tdata !== m_data) || ovr !== 16'(m_ovr)) begin
        errors++;
        $display("FAIL sat_cycle %0d: got v=%b d=%h o=%0d want v=%b d=%h o=%0d", i, tvalid, tdata, ovr, m_vld, m_data, m_ovr);
      end
    end
    trigger = 0;
    checks++; if (ovr !== 16'hFFFF) begin errors++; $display("FAIL sat_overrun: got %h want ffff", ovr); end
    checks++; if (xs != 0) begin errors++; $display("FAIL sat_no_x: got %0d cycles with X want 0", xs); end
    checks++; if (bad_gap != 0 || pulses < 600) begin errors++; $display("FAIL sat_period: bad_gaps=%0d pulses=%0d want 0 and >=600", bad_gap, pulses); end
  endtask

  task automatic test_wide();
    int tv_at = -1;
    logic [W2-1:0] tv_data = '0;
    apply_reset();
    tready2 = 1;
    adc2_sample = 18'h2ABCD;
    trigger2 = 1;
    tick();
    trigger2 = 0;
    for (int rel = 0; rel < 60; rel++) begin
      if (tvalid2 && tv_at < 0) begin tv_at = rel; tv_data = tdata2; end
      tick();
    end
    checks++; if (tv_at != 37) begin errors++; $display("FAIL wide_latency: got %0d want 37", tv_at); end
    checks++; if (tv_data !== 18'h2ABCD) begin errors++; $display("FAIL wide_tdata: got %h want 2abcd", tv_data); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    test_wide();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
